// File: rtl/ntt_ctrl.sv
// ntt_ctrl: address/zeta sequencer for a 7-layer in-place forward Kyber NTT.
// Issues one butterfly per cycle and delays the read addresses through a
// shift register so ntt_cal results are written back to the same locations.
module ntt_ctrl #(
  parameter int unsigned CAL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [7:0]         rd_addr_a,
  output logic [7:0]         rd_addr_b,
  input  logic signed [15:0] rd_data_a,
  input  logic signed [15:0] rd_data_b,
  output logic [6:0]         zeta_idx,
  input  logic signed [15:0] zeta_data,
  output logic               cal_set,
  output logic signed [15:0] cal_f1,
  output logic signed [15:0] cal_f2,
  output logic signed [15:0] cal_zeta,
  input  logic signed [15:0] cal_r1,
  input  logic signed [15:0] cal_r2,
  output logic               wr_en,
  output logic [7:0]         wr_addr_a,
  output logic [7:0]         wr_addr_b,
  output logic signed [15:0] wr_data_a,
  output logic signed [15:0] wr_data_b
);

  localparam int unsigned AW    = 8;
  localparam int unsigned LW    = 3;
  localparam int unsigned IW    = 7;
  localparam int unsigned ZW    = 7;
  localparam int unsigned PIPE  = CAL_LAT + 1;
  localparam int unsigned CNT_W = (CAL_LAT < 1) ? 1 : $clog2(CAL_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wb_t;

  state_t           state, state_nxt;
  logic [LW-1:0]    l, l_nxt;
  logic [IW-1:0]    i, i_nxt;
  logic [CNT_W-1:0] drain, drain_nxt;
  logic             issue_nxt;
  logic [AW-1:0]    len, mask, i_ext, addr_a_nxt, addr_b_nxt;
  logic [ZW-1:0]    zeta_nxt;
  wb_t              sr [PIPE];

  // Next-state and layer/butterfly/drain counter update
  always_comb begin
    state_nxt = state;
    l_nxt     = l;
    i_nxt     = i;
    drain_nxt = drain;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          l_nxt     = '0;
          i_nxt     = '0;
        end
      end
      ISSUE: begin
        i_nxt = i + IW'(1);
        if (i == IW'(127)) begin
          state_nxt = DRAIN;
          drain_nxt = CNT_W'(CAL_LAT);
        end
      end
      DRAIN: begin
        if (drain == '0) begin
          if (l == LW'(6)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ISSUE;
            l_nxt     = l + LW'(1);
            i_nxt     = '0;
          end
        end else begin
          drain_nxt = drain - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Butterfly addresses for the next issue: insert a zero at bit log2(len) of i
  always_comb begin
    issue_nxt  = (state_nxt == ISSUE);
    len        = AW'(8'd128 >> l_nxt);
    mask       = len - AW'(1);
    i_ext      = AW'(i_nxt);
    addr_a_nxt = ((i_ext & ~mask) << 1) | (i_ext & mask);
    addr_b_nxt = addr_a_nxt | len;
    zeta_nxt   = (ZW'(1) << l_nxt) + ZW'(i_nxt >> (LW'(7) - l_nxt));
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      l     <= '0;
      i     <= '0;
      drain <= '0;
    end else begin
      state <= state_nxt;
      l     <= l_nxt;
      i     <= i_nxt;
      drain <= drain_nxt;
    end
  end

  // Registered issue strobe, addresses and status
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      zeta_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en     <= issue_nxt;
      rd_addr_a <= issue_nxt ? addr_a_nxt : '0;
      rd_addr_b <= issue_nxt ? addr_b_nxt : '0;
      zeta_idx  <= issue_nxt ? zeta_nxt : '0;
      busy      <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
      done      <= (state_nxt == DONE);
    end
  end

  // Write-back shift register; reset drops any in-flight writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(PIPE); k++) sr[k] <= '0;
    end else begin
      sr[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int k = 1; k < int'(PIPE); k++) sr[k] <= sr[k-1];
    end
  end

  assign cal_set   = sr[0].vld;
  assign cal_f1    = rd_data_a;
  assign cal_f2    = rd_data_b;
  assign cal_zeta  = zeta_data;
  assign wr_en     = sr[PIPE-1].vld;
  assign wr_addr_a = sr[PIPE-1].a;
  assign wr_addr_b = sr[PIPE-1].b;
  assign wr_data_a = cal_r1;
  assign wr_data_b = cal_r2;

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: bench for ntt_ctrl with RAM/ROM models and a behavioural ntt_cal.
module tb_ntt_ctrl;

  localparam int unsigned CAL_LAT = 3;
  localparam int LAYER    = 129 + CAL_LAT;
  localparam int LAST_ISS = 1 + 6 * LAYER + 127;
  localparam int LAST_WR  = LAST_ISS + 1 + CAL_LAT;
  localparam int DONE_CYC = LAST_WR + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
    int z;
  } ev_t;

  logic               clk, rst, start, load;
  logic               busy, done, rd_en, cal_set, wr_en;
  logic [7:0]         rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0]         zeta_idx;
  logic signed [15:0] rd_data_a, rd_data_b, zeta_data;
  logic signed [15:0] cal_f1, cal_f2, cal_zeta, cal_r1, cal_r2;
  logic signed [15:0] wr_data_a, wr_data_b;

  int errors = 0;
  int checks = 0;
  int clk_cnt = 0;
  int t0 = 0;

  ev_t     iss_q[$];
  ev_t     wr_q[$];
  shortint gold [256];
  logic signed [15:0] ram [256];
  logic signed [15:0] p1 [CAL_LAT];
  logic signed [15:0] p2 [CAL_LAT];

  int pt_c [8] = '{1, 2, 133, 197, 793, 794, 795, 920};
  int pt_a [8] = '{0, 1, 0, 128, 0, 1, 4, 253};
  int pt_b [8] = '{128, 129, 64, 192, 2, 3, 6, 255};
  int pt_z [8] = '{1, 1, 2, 3, 64, 64, 65, 127};

  shortint zetas [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  ntt_ctrl #(.CAL_LAT(CAL_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .zeta_idx(zeta_idx), .zeta_data(zeta_data),
    .cal_set(cal_set), .cal_f1(cal_f1), .cal_f2(cal_f2), .cal_zeta(cal_zeta),
    .cal_r1(cal_r1), .cal_r2(cal_r2),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  // Montgomery multiply as in the Kyber reference code
  function automatic shortint fqmul(input shortint a, input shortint b);
    int p, m, r;
    shortint lo, t;
    p  = int'(a) * int'(b);
    lo = shortint'(p);
    m  = int'(lo) * -3327;
    t  = shortint'(m);
    r  = (p - int'(t) * 3329) >>> 16;
    return shortint'(r);
  endfunction

  // Coefficient RAM and zeta ROM, 1-cycle read latency
  always @(posedge clk) begin
    if (load) begin
      for (int n = 0; n < 256; n++) ram[n] <= 16'(n);
    end else if (wr_en) begin
      ram[wr_addr_a] <= wr_data_a;
      ram[wr_addr_b] <= wr_data_b;
    end
    if (rd_en) begin
      rd_data_a <= ram[rd_addr_a];
      rd_data_b <= ram[rd_addr_b];
      zeta_data <= zetas[zeta_idx];
    end
  end

  // Behavioural ntt_cal butterfly with CAL_LAT pipeline stages
  always @(posedge clk) begin
    if (cal_set) begin
      p1[0] <= cal_f1 + fqmul(cal_zeta, cal_f2);
      p2[0] <= cal_f1 - fqmul(cal_zeta, cal_f2);
    end
    for (int k = 1; k < int'(CAL_LAT); k++) begin
      p1[k] <= p1[k-1];
      p2[k] <= p2[k-1];
    end
  end
  assign cal_r1 = p1[CAL_LAT-1];
  assign cal_r2 = p2[CAL_LAT-1];

  // Software Kyber NTT of f[n]=n; also queues the expected issue/write order
  task automatic build_expect();
    int k, lay, n;
    shortint z, t;
    ev_t e;
    iss_q.delete();
    wr_q.delete();
    for (int j = 0; j < 256; j++) gold[j] = shortint'(j);
    k = 1;
    lay = 0;
    for (int len = 128; len >= 2; len = len >> 1) begin
      n = 0;
      for (int st = 0; st < 256; st = st + 2 * len) begin
        z = zetas[k];
        for (int j = st; j < st + len; j++) begin
          t = fqmul(z, gold[j+len]);
          gold[j+len] = shortint'(gold[j] - t);
          gold[j]     = shortint'(gold[j] + t);
          e.cyc = 1 + lay * LAYER + n;
          e.a = j;
          e.b = j + len;
          e.z = k;
          iss_q.push_back(e);
          e.cyc = e.cyc + 1 + int'(CAL_LAT);
          wr_q.push_back(e);
          n++;
        end
        k++;
      end
      lay++;
    end
  endtask

  // One full transform from start to done; optional extra start pulse at cycle poke
  task automatic run_ntt(input int poke);
    ev_t  e, w;
    int   rel;
    logic exp_rd, exp_wr, exp_set, exp_busy, exp_done;
    build_expect();
    @(negedge clk);
    start = 1'b1;
    load  = 1'b1;
    t0    = clk_cnt;
    exp_set = 1'b0;
    for (int c = 1; c <= DONE_CYC; c++) begin
      @(negedge clk);
      rel   = clk_cnt - t0;
      load  = 1'b0;
      start = (rel == poke);
      exp_rd = (iss_q.size() > 0) && (iss_q[0].cyc == rel);
      exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == rel);
      if (exp_rd) e = iss_q.pop_front();
      if (exp_wr) w = wr_q.pop_front();
      checks++;
      if (rd_en !== exp_rd) begin
        errors++;
        $display("FAIL rd_en cyc=%0d got=%b want=%b", rel, rd_en, exp_rd);
      end else if (exp_rd) begin
        checks++;
        if (rd_addr_a !== 8'(e.a) || rd_addr_b !== 8'(e.b) || zeta_idx !== 7'(e.z)) begin
          errors++;
          $display("FAIL rd_addr cyc=%0d got a=%0d b=%0d idx=%0d want a=%0d b=%0d idx=%0d",
                   rel, rd_addr_a, rd_addr_b, zeta_idx, e.a, e.b, e.z);
        end
      end
      checks++;
      if (wr_en !== exp_wr) begin
        errors++;
        $display("FAIL wr_en cyc=%0d got=%b want=%b", rel, wr_en, exp_wr);
      end else if (exp_wr) begin
        checks++;
        if (wr_addr_a !== 8'(w.a) || wr_addr_b !== 8'(w.b)) begin
          errors++;
          $display("FAIL wr_addr cyc=%0d got a=%0d b=%0d want a=%0d b=%0d",
                   rel, wr_addr_a, wr_addr_b, w.a, w.b);
        end
      end
      checks++;
      if (cal_set !== exp_set) begin
        errors++;
        $display("FAIL cal_set cyc=%0d got=%b want=%b", rel, cal_set, exp_set);
      end
      exp_set  = exp_rd;
      exp_busy = (rel <= LAST_WR);
      exp_done = (rel == DONE_CYC);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b want=%b", rel, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done cyc=%0d got=%b want=%b", rel, done, exp_done);
      end
      for (int p = 0; p < 8; p++) begin
        if (rel == pt_c[p]) begin
          checks++;
          if (rd_en !== 1'b1 || rd_addr_a !== 8'(pt_a[p]) || rd_addr_b !== 8'(pt_b[p]) ||
              zeta_idx !== 7'(pt_z[p])) begin
            errors++;
            $display("FAIL point cyc=%0d got en=%b a=%0d b=%0d idx=%0d want a=%0d b=%0d idx=%0d",
                     rel, rd_en, rd_addr_a, rd_addr_b, zeta_idx, pt_a[p], pt_b[p], pt_z[p]);
          end
        end
      end
      if (rel == 5) begin
        checks++;
        if (wr_en !== 1'b1 || wr_addr_a !== 8'd0 || wr_addr_b !== 8'd128) begin
          errors++;
          $display("FAIL first_write cyc=5 got en=%b a=%0d b=%0d want en=1 a=0 b=128",
                   wr_en, wr_addr_a, wr_addr_b);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (iss_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got issues=%0d writes=%0d want 0/0", iss_q.size(), wr_q.size());
    end
    for (int n = 0; n < 256; n++) begin
      checks++;
      if (ram[n] !== gold[n]) begin
        errors++;
        $display("FAIL ram[%0d] got=%0d want=%0d", n, ram[n], gold[n]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, rd_en, cal_set, wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=00000", {busy, done, rd_en, cal_set, wr_en});
    end
    checks++;
    if ({rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, zeta_idx} !== '0) begin
      errors++;
      $display("FAIL reset_addr got a=%0d b=%0d wa=%0d wb=%0d idx=%0d want all 0",
               rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, zeta_idx);
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL idle got busy=%b rd_en=%b want 0/0", busy, rd_en);
      end
    end
  endtask

  task automatic test_full_ntt();
    run_ntt(-1);
  endtask

  // Start again in the cycle after done
  task automatic test_back_to_back();
    run_ntt(-1);
  endtask

  task automatic test_start_ignored();
    run_ntt(300);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1;
    load  = 1'b1;
    t0    = clk_cnt;
    do begin
      @(negedge clk);
      start = 1'b0;
      load  = 1'b0;
    end while (clk_cnt - t0 < 50);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_en got=%b want=0", rd_en); end
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_en got=%b want=0", wr_en); end
    checks++;
    if (cal_set !== 1'b0) begin errors++; $display("FAIL mid_rst_cal_set got=%b want=0", cal_set); end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL after_rst got wr_en=%b rd_en=%b want 0/0", wr_en, rd_en);
      end
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (rd_en !== 1'b1 || busy !== 1'b1 || rd_addr_a !== 8'd0 || rd_addr_b !== 8'd128 ||
        zeta_idx !== 7'd1) begin
      errors++;
      $display("FAIL restart got en=%b busy=%b a=%0d b=%0d idx=%0d want en=1 busy=1 a=0 b=128 idx=1",
               rd_en, busy, rd_addr_a, rd_addr_b, zeta_idx);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    load  = 1'b0;
    test_reset();
    test_full_ntt();
    test_back_to_back();
    test_start_ignored();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer that runs one complete 7-layer forward Kyber NTT over a 256-coefficient polynomial held in a dual-port coefficient RAM. It generates butterfly read addresses and zeta ROM indices, and feeds operand pairs to the `ntt_cal` butterfly unit. It writes `ntt_cal` results back in place and reports completion. It sits directly upstream of `ntt_cal` (drives `set`, `f1`, `f2`, `zeta`) and also consumes `r1`/`r2` for write-back.

## Interface
- `CAL_LAT`, default 3: cycles from `ntt_cal` inputs (with `set`=1) to valid `r1`/`r2`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `busy` out 1: high from first issue cycle through last write-back cycle.
- `done` out 1: one-cycle pulse after the final write-back.
- `rd_en` out 1: RAM read strobe (1-cycle read latency).
- `rd_addr_a`, `rd_addr_b` out 8: butterfly operand addresses j, j+len.
- `rd_data_a`, `rd_data_b` in 16 signed: RAM read data.
- `zeta_idx` out 7: zeta ROM index (1-cycle latency, read alongside `rd_en`).
- `zeta_data` in 16 signed: ROM data.
- `cal_set` out 1: `ntt_cal` `set`.
- `cal_f1`, `cal_f2`, `cal_zeta` out 16 signed: combinational passthrough of `rd_data_a`, `rd_data_b`, `zeta_data`.
- `cal_r1`, `cal_r2` in 16 signed: `ntt_cal` results.
- `wr_en` out 1: RAM write strobe.
- `wr_addr_a`, `wr_addr_b` out 8: write-back addresses.
- `wr_data_a`, `wr_data_b` out 16 signed: `cal_r1`, `cal_r2` passthrough.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE when `start`=1. The layer counter `l` (0..6) and butterfly counter `i` (0..127) are cleared.
- In ISSUE, one butterfly is issued per cycle:
  - `rd_en`=1.
  - len = 128>>l, g = i>>(7−l).
  - `rd_addr_a` = 2·len·g + (i mod len); `rd_addr_b` = `rd_addr_a` + len.
  - `zeta_idx` = (1<<l) + g.
- ISSUE → DRAIN after i=127, with a drain counter of 1+`CAL_LAT` cycles. DRAIN prevents read-after-write hazards across layers. Within a layer, every address is touched exactly once, so there are no hazards.
- At DRAIN end:
  - If l<6: l++, i=0, go to ISSUE.
  - If l=6: go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Issue pipeline:
  - `cal_set` = `rd_en` delayed 1 cycle.
  - `wr_en` and `wr_addr_a`/`wr_addr_b` = `rd_en` and the read addresses delayed 1+`CAL_LAT` cycles through a shift register.
- `start` is ignored outside IDLE.
- No arithmetic is performed here. Data widths pass through unchanged.
- `rst` at any time, including mid-layer:
  - Next state is IDLE and all counters clear.
  - The shift register clears, so in-flight writes are dropped.
  - RAM contents are then undefined and need a reload.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `cal_set`, `wr_en` = 0. All address outputs, `zeta_idx` = 0.
- Cycle 0 = the cycle `start` is sampled in IDLE. First issue is at cycle 1, and `busy` rises at cycle 1.
- Read issued at cycle t:
  - `cal_set`=1 with operands at t+1.
  - `wr_en`=1 at t+1+`CAL_LAT`.
- Layer period = 128 + 1 + `CAL_LAT` cycles. Layer l issues at cycles 1 + l·(129+`CAL_LAT`) … +127.
- With `CAL_LAT`=3:
  - Last issue at cycle 920.
  - Last write at 924.
  - `done` at 925, with `busy` low at 925.
- Back-to-back: `start` in the cycle after `done` (IDLE) is accepted.

## Test plan
- Reset: hold `rst` 2 cycles → every output 0. Release with `start`=0 for 10 cycles → `busy`=0, `rd_en`=0.
- Layer-0 and layer-1 addressing: pulse `start` at cycle 0 → expect:
  - cycle 1: a=0, b=128, `zeta_idx`=1.
  - cycle 2: a=1, b=129.
  - cycle 133: a=0, b=64, idx 2.
  - cycle 197: a=128, b=192, idx 3.
- Layer-6 addressing:
  - cycle 793: a=0, b=2, idx 64.
  - cycle 794: a=1, b=3, idx 64.
  - cycle 795: a=4, b=6, idx 65.
  - cycle 920: a=253, b=255, idx 127.
- Pipeline and completion, with `CAL_LAT`=3 and a real `ntt_cal` plus RAM/ROM models:
  - `wr_en` at cycle 5 with addresses 0/128.
  - No `rd_en` during cycles 129–132.
  - `done` exactly at 925.
  - Final RAM contents equal a software Kyber NTT (Montgomery zetas, e.g. zetas[1] = −758) of the input f[n]=n.
- `start` pulsed at cycle 300 while busy → no effect, and `done` still occurs only at 925.
- Reset at cycle 50 mid-layer:
  - Cycle 51: `busy`, `rd_en`, `wr_en`, `cal_set` = 0, with no further writes.
  - New `start` → first issue a=0, b=128, idx 1.
